miriscv_data_arb: RTL and testbench
===================================

# miriscv_data_arb

Two-master arbiter for the single data port of `miriscv_ram`. It shares that port between the core load/store unit (master 0) and a second requester such as a program loader or DMA (master 1). It grants at most one access per cycle, decodes the RAM address range, and returns each read response or write acknowledge to the master that issued it one cycle after the grant. It sits between the masters and the `miriscv_ram` data port inside `miriscv_top`.

## Interface
Parameters:
- `RAM_SIZE`, 256: RAM size in bytes. Addresses `>= RAM_SIZE` are out of range.

Ports (the `mN_` signals exist for N = 0 and N = 1):
- Reset is synchronous and active-high: `rst_i`. The clock is `clk_i`.
- `clk_i` in 1: system clock, all state updates on the rising edge.
- `rst_i` in 1: synchronous active-high reset.
- `mN_req_i` in 1: access request. Held with its attributes until granted.
- `mN_we_i` in 1: 1 = write, 0 = read.
- `mN_be_i` in 4: byte enables.
- `mN_addr_i` in 32: byte address.
- `mN_wdata_i` in 32: write data.
- `mN_gnt_o` out 1: request accepted this cycle.
- `mN_rvalid_o` out 1: response for the access granted in the previous cycle.
- `mN_rdata_o` out 32: read data, valid while `mN_rvalid_o` is high, otherwise 0.
- `mN_err_o` out 1: the response is for an out-of-range access. Qualified by `mN_rvalid_o`.
- `ram_req_o` out 1: RAM data request.
- `ram_we_o` out 1: RAM write enable.
- `ram_be_o` out 4: RAM byte enables.
- `ram_addr_o` out 32: RAM address.
- `ram_wdata_o` out 32: RAM write data.
- `ram_rdata_i` in 32: RAM read data, registered by the RAM, valid one cycle after `ram_req_o`.

## Operation
- **Grant.** Each cycle at most one `mN_gnt_o` is high, only for a master whose `mN_req_i` is high. With one requester, that requester is granted. With both requesting, the arbitration policy applies (see Configuration).
- **Forwarding.** The granted master's `we`, `be`, `addr` and `wdata` drive the RAM outputs combinationally. With no grant, `ram_req_o` = 0 and the other RAM outputs are 0.
- **Range check.** If `addr >= RAM_SIZE`:
  - the grant is still given;
  - `ram_req_o` stays 0, so no RAM write occurs;
  - the response carries `err` = 1 and `rdata` = 0.
- **Response FSM.** States IDLE and RESP, plus registers `resp_id`, `resp_err` and `resp_we`.
  - Any grant moves the FSM to RESP and captures the master id and error flag.
  - A cycle with no grant moves the FSM to IDLE.
  - In RESP, the captured master gets `rvalid` = 1 for one cycle.
  - `rdata` = `ram_rdata_i` for an in-range read. It is 0 for a write or an error.
  - `err` = `resp_err`.
- **Back-to-back.** A new grant is allowed in the same cycle as a pending response (RESP → RESP), so sustained throughput is one access per cycle.
- **Requester rules.** A master must not change its request attributes while `req` is high and `gnt` is low. The arbiter does not check this.

## Timing
- Grant latency: 0 cycles. `mN_gnt_o` is combinational from the `req` inputs and the arbitration state.
- Response latency: exactly 1 cycle after the grant, for reads, writes and errors alike.
- No combinational path exists from `ram_rdata_i` to any `gnt` output.
- **Reset**, while `rst_i` is high:
  - FSM goes to IDLE, `last_grant` = 1 (so master 0 wins first), `resp_*` = 0;
  - all `gnt`, `rvalid` and `err` outputs are 0, and `ram_req_o` = 0;
  - a grant in the cycle before reset produces no response after reset.
- **Simultaneous events:**
  - a response to master X and a new grant to master Y may occur in the same cycle;
  - a master may be re-granted in the cycle it receives its response.

## Configuration
- `MIRISCV_ARB_RR_EN` defined: round-robin arbitration.
  - The `last_grant` register updates on every grant.
  - On a conflict, the master other than `last_grant` wins.
  - No requester waits more than one cycle while the other is also requesting.
- `MIRISCV_ARB_RR_EN` undefined: fixed priority, master 0 always wins.
  - Master 1 can starve.
  - The `last_grant` register is omitted.

## Test plan
- **Single read, master 0.** After reset, `m0` reads addr 0x10 holding 0xDEADBEEF → `m0_gnt_o` = 1 in cycle N; `m0_rvalid_o` = 1 with rdata 0xDEADBEEF and `err` = 0 in cycle N+1.
- **Write then read, master 1.** `m1` writes 0x12345678 to addr 0x20 with `be` = 4'b0011, then reads 0x20 (initially 0) → the read returns 0x00005678.
- **Out of range.** `m0` writes addr 0x100 with `RAM_SIZE` = 256 → `gnt` = 1 and `ram_req_o` = 0. Next cycle: `rvalid` = 1, `err` = 1, `rdata` = 0, and the RAM contents are unchanged.
- **Contention.** Both masters hold `req` for 4 cycles:
  - with `MIRISCV_ARB_RR_EN`: grants go m0, m1, m0, m1;
  - without it: m0 is granted all 4 cycles;
  - in both cases each response returns to the correct master.
- **Reset mid-operation.** `m1` read granted in cycle N, `rst_i` = 1 in cycle N+1 → no `rvalid` in cycle N+1, and all outputs are 0 during reset.
- **Back-to-back.** `m0` reads 0x0, 0x4 and 0x8 in consecutive cycles → three consecutive `rvalid` pulses carrying the correct data in order.

Source files
------------

// File: rtl/miriscv_data_arb.sv
// miriscv_data_arb
// ----------------
// Two-master arbiter for the single data port of miriscv_ram. Master 0 is the
// core load/store unit and master 1 is a secondary requester (loader / DMA).
// At most one access is granted per cycle. The granted master's attributes are
// forwarded combinationally to the RAM. Every grant, including one to an
// out-of-range address, produces exactly one response to the issuing master
// one cycle later.
//
// Configuration macro:
//   MIRISCV_ARB_RR_EN  defined   -> round-robin arbitration on conflict
//                      undefined -> fixed priority, master 0 always wins
//
// Parameters:
//   RAM_SIZE      RAM size in bytes; addresses >= RAM_SIZE are out of range
//
// Ports (N = 0, 1):
//   clk_i         system clock, rising edge
//   rst_i         synchronous active-high reset
//   mN_req_i      access request, held with attributes until granted
//   mN_we_i       1 = write, 0 = read
//   mN_be_i       byte enables
//   mN_addr_i     byte address
//   mN_wdata_i    write data
//   mN_gnt_o      request accepted this cycle (combinational)
//   mN_rvalid_o   response for the access granted in the previous cycle
//   mN_rdata_o    read data while mN_rvalid_o is high, otherwise 0
//   mN_err_o      response belongs to an out-of-range access
//   ram_req_o     RAM data request
//   ram_we_o      RAM write enable
//   ram_be_o      RAM byte enables
//   ram_addr_o    RAM byte address
//   ram_wdata_o   RAM write data
//   ram_rdata_i   RAM read data, valid one cycle after ram_req_o

module miriscv_data_arb #(
  parameter int unsigned RAM_SIZE = 256
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [3:0]  m0_be_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  output logic        m0_err_o,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_be_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        m1_err_o,

  output logic        ram_req_o,
  output logic        ram_we_o,
  output logic [3:0]  ram_be_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_wdata_o,
  input  logic [31:0] ram_rdata_i
);

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned BEW = 4;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_e;

  state_e state_q, state_d;
  logic   resp_id_q,  resp_id_d;
  logic   resp_err_q, resp_err_d;
  logic   resp_we_q,  resp_we_d;

  logic           gnt0_c;
  logic           gnt1_c;
  logic           gnt_any_c;
  logic           sel_we_c;
  logic [BEW-1:0] sel_be_c;
  logic [AW-1:0]  sel_addr_c;
  logic [DW-1:0]  sel_wdata_c;
  logic           oor_c;
  logic           resp_active_c;
  logic [DW-1:0]  resp_data_c;

  // ---------------------------------------------------------------------------
  // Arbitration. Grants are suppressed during reset so nothing reaches the RAM
  // and no response is scheduled out of a reset cycle.
  // ---------------------------------------------------------------------------
`ifdef MIRISCV_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  // On conflict the master that was not granted last wins.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!rst_i) begin
      if (m0_req_i && m1_req_i) begin
        if (last_grant_q) begin
          gnt0_c = 1'b1;
        end else begin
          gnt1_c = 1'b1;
        end
      end else begin
        gnt0_c = m0_req_i;
        gnt1_c = m1_req_i;
      end
    end
  end

  // Remember the owner of every grant, conflicting or not.
  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt0_c) begin
      last_grant_d = 1'b0;
    end else if (gnt1_c) begin
      last_grant_d = 1'b1;
    end
  end

  // Reset value 1 lets master 0 win the first conflict.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  // Fixed priority: master 0 always wins a conflict.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!rst_i) begin
      gnt0_c = m0_req_i;
      gnt1_c = m1_req_i && !m0_req_i;
    end
  end
`endif

  assign gnt_any_c = gnt0_c | gnt1_c;
  assign m0_gnt_o  = gnt0_c;
  assign m1_gnt_o  = gnt1_c;

  // ---------------------------------------------------------------------------
  // Attribute mux of the granted master and address range check.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_we_c    = m0_we_i;
    sel_be_c    = m0_be_i;
    sel_addr_c  = m0_addr_i;
    sel_wdata_c = m0_wdata_i;
    if (gnt1_c) begin
      sel_we_c    = m1_we_i;
      sel_be_c    = m1_be_i;
      sel_addr_c  = m1_addr_i;
      sel_wdata_c = m1_wdata_i;
    end
  end

  assign oor_c = (sel_addr_c >= AW'(RAM_SIZE));

  // RAM port drive. Out-of-range grants keep ram_req_o low so the RAM is
  // never touched, while the attributes are still forwarded.
  always_comb begin
    ram_req_o   = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (gnt_any_c) begin
      ram_req_o   = !oor_c;
      ram_we_o    = sel_we_c;
      ram_be_o    = sel_be_c;
      ram_addr_o  = sel_addr_c;
      ram_wdata_o = sel_wdata_c;
    end
  end

  // ---------------------------------------------------------------------------
  // Response FSM: any grant schedules a response for the next cycle; RESP may
  // be re-entered directly, giving one access per cycle throughput.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      resp_id_q  <= 1'b0;
      resp_err_q <= 1'b0;
      resp_we_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      resp_id_q  <= resp_id_d;
      resp_err_q <= resp_err_d;
      resp_we_q  <= resp_we_d;
    end
  end

  always_comb begin
    state_d    = S_IDLE;
    resp_id_d  = resp_id_q;
    resp_err_d = resp_err_q;
    resp_we_d  = resp_we_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (gnt_any_c) begin
          state_d    = S_RESP;
          resp_id_d  = gnt1_c;
          resp_err_d = oor_c;
          resp_we_d  = sel_we_c;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Response routing. The reset term blanks a response that was scheduled by
  // a grant in the cycle just before reset was asserted.
  // ---------------------------------------------------------------------------
  assign resp_active_c = (state_q == S_RESP) && !rst_i;

  // Only an in-range read carries RAM data; writes and errors return zero.
  assign resp_data_c = (resp_err_q || resp_we_q) ? '0 : ram_rdata_i;

  assign m0_rvalid_o = resp_active_c && !resp_id_q;
  assign m1_rvalid_o = resp_active_c &&  resp_id_q;

  assign m0_rdata_o  = m0_rvalid_o ? resp_data_c : '0;
  assign m1_rdata_o  = m1_rvalid_o ? resp_data_c : '0;

  assign m0_err_o    = m0_rvalid_o && resp_err_q;
  assign m1_err_o    = m1_rvalid_o && resp_err_q;

endmodule

// File: tb/tb_miriscv_data_arb.sv
`timescale 1ns/1ps
// Bench for miriscv_data_arb: directed scenarios plus a randomized run, all
// compared against a transaction-level model (byte memory + pending response).
module tb_miriscv_data_arb;

  localparam int unsigned RAM_SIZE = 256;
  localparam int unsigned WORDS    = RAM_SIZE / 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_be, m1_be;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_req_o, ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic [31:0] ram_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  miriscv_data_arb #(.RAM_SIZE(RAM_SIZE)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid),
    .m0_rdata_o(m0_rdata), .m0_err_o(m0_err),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid),
    .m1_rdata_o(m1_rdata), .m1_err_o(m1_err),
    .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata)
  );

  // Behavioural RAM: registered read, byte-enabled write.
  logic [31:0] ram_mem [WORDS];
  always @(posedge clk) begin
    if (ram_req_o) begin
      ram_rdata <= ram_mem[ram_addr_o[7:2]];
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be_o[b]) ram_mem[ram_addr_o[7:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
        end
      end
    end
  end

  // Reference model state.
  logic [7:0]  ref_mem [RAM_SIZE];
  bit          ref_last;
  bit          pend_v, pend_id, pend_err, pend_we;
  logic [31:0] pend_data;
  int          win;
  logic        exp_gnt0, exp_gnt1, exp_ram_req, exp_rv0, exp_rv1, exp_err0, exp_err1;
  logic [31:0] exp_rd0, exp_rd1;
  logic        exp_we;
  logic [3:0]  exp_be;
  logic [31:0] exp_addr, exp_wdata;

  // Predict this cycle's outputs from the current inputs and pending response.
  task automatic model_eval();
    win = -1;
    if (!rst) begin
      if (m0_req && m1_req) begin
`ifdef MIRISCV_ARB_RR_EN
        win = ref_last ? 0 : 1;
`else
        win = 0;
`endif
      end else if (m0_req) win = 0;
      else if (m1_req) win = 1;
    end
    exp_gnt0 = (win == 0);
    exp_gnt1 = (win == 1);
    exp_we = 1'b0; exp_be = 4'h0; exp_addr = 32'h0; exp_wdata = 32'h0;
    if (win == 0) begin
      exp_we = m0_we; exp_be = m0_be; exp_addr = m0_addr; exp_wdata = m0_wdata;
    end else if (win == 1) begin
      exp_we = m1_we; exp_be = m1_be; exp_addr = m1_addr; exp_wdata = m1_wdata;
    end
    exp_ram_req = (win >= 0) && (exp_addr < RAM_SIZE);
    exp_rv0  = !rst && pend_v && !pend_id;
    exp_rv1  = !rst && pend_v && pend_id;
    exp_err0 = exp_rv0 && pend_err;
    exp_err1 = exp_rv1 && pend_err;
    exp_rd0  = (exp_rv0 && !pend_err && !pend_we) ? pend_data : 32'h0;
    exp_rd1  = (exp_rv1 && !pend_err && !pend_we) ? pend_data : 32'h0;
  endtask

  // Retire this cycle into the model: schedule response, apply writes.
  task automatic model_commit();
    logic [7:0] ai;
    if (rst) begin
      pend_v = 0; pend_id = 0; pend_err = 0; pend_we = 0; ref_last = 1;
    end else if (win < 0) begin
      pend_v = 0;
    end else begin
      pend_v    = 1;
      pend_id   = (win == 1);
      pend_we   = exp_we;
      pend_err  = (exp_addr >= RAM_SIZE);
      pend_data = 32'h0;
      if (!pend_err) begin
        ai = exp_addr[7:0] & 8'hFC;
        pend_data = {ref_mem[ai + 8'd3], ref_mem[ai + 8'd2], ref_mem[ai + 8'd1], ref_mem[ai]};
        if (exp_we) begin
          for (int b = 0; b < 4; b++) begin
            if (exp_be[b]) ref_mem[ai + 8'(b)] = exp_wdata[8*b +: 8];
          end
        end
      end
      ref_last = (win == 1);
    end
  endtask

  task automatic settle();
    model_eval();
    #1;
  endtask

  task automatic advance();
    model_commit();
    @(negedge clk);
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_be = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
    m1_req = 0; m1_we = 0; m1_be = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    ram_mem[addr[7:2]] = data;
    for (int b = 0; b < 4; b++) ref_mem[{addr[7:2], 2'b00} + 8'(b)] = data[8*b +: 8];
  endtask

  task automatic do_reset();
    rst = 1; idle();
    settle(); advance();
    settle(); advance();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    m0_req = 1; m1_req = 1;
    settle();
    vectors++; if (m0_gnt !== 1'b0) begin miscompares++; $display("FAIL reset_gnt0: got %b expected 0", m0_gnt); end
    vectors++; if (m1_gnt !== 1'b0) begin miscompares++; $display("FAIL reset_gnt1: got %b expected 0", m1_gnt); end
    vectors++; if (ram_req_o !== 1'b0) begin miscompares++; $display("FAIL reset_ram_req: got %b expected 0", ram_req_o); end
    vectors++; if ({m0_rvalid, m1_rvalid, m0_err, m1_err} !== 4'b0) begin miscompares++;
      $display("FAIL reset_resp: got rv0=%b rv1=%b e0=%b e1=%b expected all 0", m0_rvalid, m1_rvalid, m0_err, m1_err); end
    advance();
    rst = 0; idle();
    settle();
    vectors++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin miscompares++;
      $display("FAIL post_reset_rvalid: got %b%b expected 00", m0_rvalid, m1_rvalid); end
    advance();
  endtask

  task automatic test_single_read();
    preload(32'h10, 32'hDEADBEEF);
    idle(); m0_req = 1; m0_be = 4'hF; m0_addr = 32'h10;
    settle();
    vectors++; if ({m0_gnt, m1_gnt, ram_req_o} !== 3'b101) begin miscompares++;
      $display("FAIL single_gnt: got g0=%b g1=%b req=%b expected 1 0 1", m0_gnt, m1_gnt, ram_req_o); end
    vectors++; if (ram_addr_o !== 32'h10) begin miscompares++; $display("FAIL single_addr: got %h expected 00000010", ram_addr_o); end
    advance();
    idle();
    settle();
    vectors++; if ({m0_rvalid, m0_err, m1_rvalid} !== 3'b100) begin miscompares++;
      $display("FAIL single_resp: got rv0=%b err0=%b rv1=%b expected 1 0 0", m0_rvalid, m0_err, m1_rvalid); end
    vectors++; if (m0_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL single_rdata: got %h expected deadbeef", m0_rdata); end
    advance();
  endtask

  task automatic test_write_read_m1();
    idle(); m1_req = 1; m1_we = 1; m1_be = 4'b0011; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    settle();
    vectors++; if ({m1_gnt, ram_req_o, ram_we_o} !== 3'b111) begin miscompares++;
      $display("FAIL wr_gnt: got g1=%b req=%b we=%b expected 1 1 1", m1_gnt, ram_req_o, ram_we_o); end
    vectors++; if ({ram_be_o, ram_wdata_o} !== {4'b0011, 32'h12345678}) begin miscompares++;
      $display("FAIL wr_fwd: got be=%b wdata=%h expected 0011 12345678", ram_be_o, ram_wdata_o); end
    advance();
    m1_we = 0; m1_be = 4'hF; m1_wdata = 32'h0;
    settle();
    vectors++; if ({m1_rvalid, m1_err, m1_gnt} !== 3'b101 || m1_rdata !== 32'h0) begin miscompares++;
      $display("FAIL wr_ack: got rv1=%b err1=%b g1=%b rdata=%h expected 1 0 1 0", m1_rvalid, m1_err, m1_gnt, m1_rdata); end
    advance();
    idle();
    settle();
    vectors++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'h00005678) begin miscompares++;
      $display("FAIL rd_after_wr: got rv1=%b rdata=%h expected 1 00005678", m1_rvalid, m1_rdata); end
    advance();
  endtask

  task automatic test_out_of_range();
    logic [31:0] word0_before;
    word0_before = ram_mem[0];
    idle(); m0_req = 1; m0_we = 1; m0_be = 4'hF; m0_addr = 32'h100; m0_wdata = 32'hCAFEF00D;
    settle();
    vectors++; if ({m0_gnt, ram_req_o} !== 2'b10) begin miscompares++;
      $display("FAIL oor_gnt: got g0=%b req=%b expected 1 0", m0_gnt, ram_req_o); end
    advance();
    m0_we = 0; m0_addr = 32'h104; m0_wdata = 32'h0;
    settle();
    vectors++; if ({m0_rvalid, m0_err, m0_gnt} !== 3'b111 || m0_rdata !== 32'h0) begin miscompares++;
      $display("FAIL oor_wr_resp: got rv0=%b err0=%b g0=%b rdata=%h expected 1 1 1 0", m0_rvalid, m0_err, m0_gnt, m0_rdata); end
    advance();
    idle();
    settle();
    vectors++; if ({m0_rvalid, m0_err} !== 2'b11 || m0_rdata !== 32'h0) begin miscompares++;
      $display("FAIL oor_rd_resp: got rv0=%b err0=%b rdata=%h expected 1 1 0", m0_rvalid, m0_err, m0_rdata); end
    vectors++; if (ram_mem[0] !== word0_before) begin miscompares++;
      $display("FAIL oor_ram_untouched: got %h expected %h", ram_mem[0], word0_before); end
    advance();
  endtask

  task automatic test_contention();
    bit pat0 [4];
    bit prev0;
    logic [31:0] want;
`ifdef MIRISCV_ARB_RR_EN
    pat0 = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    pat0 = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    do_reset();
    prev0 = 0;
    for (int i = 0; i <= 4; i++) begin
      idle();
      if (i < 4) begin
        m0_req = 1; m0_be = 4'hF; m0_addr = 32'h10;
        m1_req = 1; m1_be = 4'hF; m1_addr = 32'h20;
      end
      settle();
      if (i < 4) begin
        vectors++; if ({m0_gnt, m1_gnt} !== {pat0[i], !pat0[i]}) begin miscompares++;
          $display("FAIL cont_gnt[%0d]: got %b%b expected %b%b", i, m0_gnt, m1_gnt, pat0[i], !pat0[i]); end
      end
      if (i > 0) begin
        want = prev0 ? 32'hDEADBEEF : 32'h00005678;
        vectors++; if ({m0_rvalid, m1_rvalid} !== {prev0, !prev0} || (prev0 ? m0_rdata : m1_rdata) !== want) begin
          miscompares++;
          $display("FAIL cont_resp[%0d]: got rv=%b%b rd0=%h rd1=%h expected rv=%b%b data %h",
                   i, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, prev0, !prev0, want);
        end
      end
      if (i < 4) prev0 = pat0[i];
      advance();
    end
  endtask

  task automatic test_reset_mid();
    idle(); m1_req = 1; m1_be = 4'hF; m1_addr = 32'h20;
    settle();
    vectors++; if (m1_gnt !== 1'b1) begin miscompares++; $display("FAIL midrst_gnt1: got %b expected 1", m1_gnt); end
    advance();
    rst = 1; idle(); m0_req = 1; m0_be = 4'hF; m0_addr = 32'h10;
    settle();
    vectors++; if ({m1_rvalid, m0_rvalid, m0_gnt, ram_req_o, m1_err} !== 5'b0 || m1_rdata !== 32'h0) begin miscompares++;
      $display("FAIL midrst_outputs: got rv1=%b rv0=%b g0=%b req=%b err1=%b rd1=%h expected all 0",
               m1_rvalid, m0_rvalid, m0_gnt, ram_req_o, m1_err, m1_rdata); end
    advance();
    rst = 0; idle();
    settle();
    vectors++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin miscompares++;
      $display("FAIL midrst_after: got rv=%b%b expected 00", m0_rvalid, m1_rvalid); end
    advance();
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    vals = '{32'h0BAD0000, 32'h0BAD0004, 32'h0BAD0008};
    for (int i = 0; i < 3; i++) preload(32'(4 * i), vals[i]);
    for (int i = 0; i <= 3; i++) begin
      idle();
      if (i < 3) begin m0_req = 1; m0_be = 4'hF; m0_addr = 32'(4 * i); end
      settle();
      if (i < 3) begin
        vectors++; if (m0_gnt !== 1'b1) begin miscompares++; $display("FAIL b2b_gnt[%0d]: got %b expected 1", i, m0_gnt); end
      end
      if (i > 0) begin
        vectors++; if (m0_rvalid !== 1'b1 || m0_rdata !== vals[i-1]) begin miscompares++;
          $display("FAIL b2b_resp[%0d]: got rv0=%b rdata=%h expected 1 %h", i, m0_rvalid, m0_rdata, vals[i-1]); end
      end
      advance();
    end
  endtask

  task automatic rand_attrs(output logic we, output logic [3:0] be, output logic [31:0] addr, output logic [31:0] wd);
    we   = 1'($urandom_range(0, 1));
    be   = 4'($urandom_range(1, 15));
    wd   = $urandom;
    if ($urandom_range(0, 9) == 0) addr = RAM_SIZE + ($urandom_range(0, 1023) << 2);
    else addr = $urandom_range(0, WORDS - 1) << 2;
  endtask

  task automatic test_random();
    bit g0p, g1p;
    g0p = 1; g1p = 1;
    idle();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      if (!m0_req || g0p) begin
        m0_req = ($urandom_range(0, 99) < 60);
        rand_attrs(m0_we, m0_be, m0_addr, m0_wdata);
      end
      if (!m1_req || g1p) begin
        m1_req = ($urandom_range(0, 99) < 60);
        rand_attrs(m1_we, m1_be, m1_addr, m1_wdata);
      end
      settle();
      vectors++; if ({m0_gnt, m1_gnt} !== {exp_gnt0, exp_gnt1}) begin miscompares++;
        $display("FAIL rnd_gnt[%0d]: got %b%b expected %b%b", c, m0_gnt, m1_gnt, exp_gnt0, exp_gnt1); end
      vectors++; if (ram_req_o !== exp_ram_req) begin miscompares++;
        $display("FAIL rnd_ram_req[%0d]: got %b expected %b", c, ram_req_o, exp_ram_req); end
      if (win < 0 || exp_ram_req) begin
        vectors++; if ({ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o} !== {exp_we, exp_be, exp_addr, exp_wdata}) begin
          miscompares++;
          $display("FAIL rnd_ram_fwd[%0d]: got we=%b be=%h a=%h d=%h expected we=%b be=%h a=%h d=%h", c,
                   ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o, exp_we, exp_be, exp_addr, exp_wdata);
        end
      end
      vectors++; if ({m0_rvalid, m0_err, m0_rdata} !== {exp_rv0, exp_err0, exp_rd0}) begin miscompares++;
        $display("FAIL rnd_m0_resp[%0d]: got rv=%b err=%b rd=%h expected rv=%b err=%b rd=%h", c,
                 m0_rvalid, m0_err, m0_rdata, exp_rv0, exp_err0, exp_rd0); end
      vectors++; if ({m1_rvalid, m1_err, m1_rdata} !== {exp_rv1, exp_err1, exp_rd1}) begin miscompares++;
        $display("FAIL rnd_m1_resp[%0d]: got rv=%b err=%b rd=%h expected rv=%b err=%b rd=%h", c,
                 m1_rvalid, m1_err, m1_rdata, exp_rv1, exp_err1, exp_rd1); end
      g0p = exp_gnt0; g1p = exp_gnt1;
      advance();
    end
    rst = 0; idle();
    settle(); advance();
  endtask

  initial begin
    for (int i = 0; i < int'(WORDS); i++) ram_mem[i] = 32'h0;
    for (int i = 0; i < int'(RAM_SIZE); i++) ref_mem[i] = 8'h0;
    ram_rdata = 32'h0;
    ref_last = 1; pend_v = 0; pend_id = 0; pend_err = 0; pend_we = 0; pend_data = 32'h0;
    rst = 1; idle();
    @(negedge clk);
    test_reset();
    test_single_read();
    test_write_read_m1();
    test_out_of_range();
    test_contention();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
